// File: rtl/machine_counter_bank.sv
// Machine-mode performance counter bank.
// Holds mcycle, minstret and NUM_HPM mhpmcounters (COUNTER_WIDTH bits each,
// exposed as 32-bit low/high CSR halves) plus the mcountinhibit register.
// Ports:
//   clk_in            core clock
//   rst_n_in          asynchronous active-low reset
//   csr_addr_in       CSR address for read and write
//   wr_en_in          CSR write strobe
//   data_wr_in        CSR write data
//   instret_in        one instruction retired this cycle
//   hpm_event_in      per-counter event pulses (bit i -> mhpmcounter(3+i))
//   data_rd_out       combinational read data for csr_addr_in
//   addr_hit_out      csr_addr_in maps to a register in this block
//   mcountinhibit_out current mcountinhibit value
module machine_counter_bank #(
  parameter int unsigned NUM_HPM             = 4,
  parameter int unsigned COUNTER_WIDTH       = 64,
  parameter logic [31:0] MCOUNTINHIBIT_RESET = 32'h0000_0000
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n_in,
  input  logic [11:0]                          csr_addr_in,
  input  logic                                 wr_en_in,
  input  logic [31:0]                          data_wr_in,
  input  logic                                 instret_in,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_in,
  output logic [31:0]                          data_rd_out,
  output logic                                 addr_hit_out,
  output logic [31:0]                          mcountinhibit_out
);

  // Counter slot 0 = mcycle, 1 = minstret, 2+i = mhpmcounter(3+i).
  localparam int unsigned NUM_CNT  = NUM_HPM + 2;
  localparam int unsigned HI_W     = COUNTER_WIDTH - 32;
  localparam logic [31:0] HPM_MASK = ((32'h0000_0001 << NUM_HPM) - 32'h0000_0001) << 3;
  localparam logic [31:0] WMASK    = 32'h0000_0005 | HPM_MASK;

  // Low-half CSR address of a counter slot; the high half sits 12'h080 above.
  // Slot 1 (minstret) lands on B02 and hpm slots on B03+i, so B01 is skipped.
  function automatic logic [11:0] cnt_lo_addr(input int unsigned k);
    logic [11:0] addr_v;
    if (k == 0) begin
      addr_v = 12'hB00;
    end else begin
      addr_v = 12'hB01 + 12'(k);
    end
    return addr_v;
  endfunction

  logic [COUNTER_WIDTH-1:0] cnt_r     [NUM_CNT];
  logic [COUNTER_WIDTH-1:0] cnt_nxt_s [NUM_CNT];
  logic [31:0]              mcountinhibit_r;
  logic [31:0]              mcountinhibit_nxt_s;
  logic [NUM_CNT-1:0]       hit_lo_s;
  logic [NUM_CNT-1:0]       hit_hi_s;
  logic [NUM_CNT-1:0]       evt_s;
  logic [NUM_CNT-1:0]       inh_s;
  logic                     mci_hit_s;
  logic [31:0]              rd_s;
  logic                     hit_s;

  // Address decode for every counter half and mcountinhibit.
  always_comb begin
    hit_lo_s  = '0;
    hit_hi_s  = '0;
    mci_hit_s = (csr_addr_in == 12'h320);
    for (int k = 0; k < NUM_CNT; k++) begin
      hit_lo_s[k] = (csr_addr_in == cnt_lo_addr(k));
      hit_hi_s[k] = (csr_addr_in == (cnt_lo_addr(k) + 12'h080));
    end
  end

  // Map each slot to its event source and its mcountinhibit gate bit.
  always_comb begin
    evt_s    = '0;
    inh_s    = '0;
    evt_s[0] = 1'b1;
    inh_s[0] = mcountinhibit_r[0];
    evt_s[1] = instret_in;
    inh_s[1] = mcountinhibit_r[2];
    for (int i = 0; i < NUM_HPM; i++) begin
      evt_s[i+2] = hpm_event_in[i];
      inh_s[i+2] = mcountinhibit_r[i+3];
    end
  end

  // Next-state: a CSR write to either half replaces the increment that cycle.
  always_comb begin
    for (int k = 0; k < NUM_CNT; k++) begin
      cnt_nxt_s[k] = cnt_r[k];
      if (wr_en_in && hit_lo_s[k]) begin
        cnt_nxt_s[k][31:0] = data_wr_in;
      end else if (wr_en_in && hit_hi_s[k]) begin
        cnt_nxt_s[k][COUNTER_WIDTH-1:32] = data_wr_in[HI_W-1:0];
      end else if (evt_s[k] && !inh_s[k]) begin
        cnt_nxt_s[k] = cnt_r[k] + COUNTER_WIDTH'(1'b1);
      end else begin
        cnt_nxt_s[k] = cnt_r[k];
      end
    end
    if (wr_en_in && mci_hit_s) begin
      mcountinhibit_nxt_s = data_wr_in & WMASK;
    end else begin
      mcountinhibit_nxt_s = mcountinhibit_r;
    end
  end

  // Read mux: OR of one-hot selected sources; unmapped addresses yield 0.
  always_comb begin
    rd_s  = {32{mci_hit_s}} & mcountinhibit_r;
    hit_s = mci_hit_s | (|hit_lo_s) | (|hit_hi_s);
    for (int k = 0; k < NUM_CNT; k++) begin
      rd_s = rd_s
           | ({32{hit_lo_s[k]}} & cnt_r[k][31:0])
           | ({32{hit_hi_s[k]}} & 32'(cnt_r[k][COUNTER_WIDTH-1:32]));
    end
  end

  // Counter and mcountinhibit state with asynchronous clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_r[k] <= '0;
      end
      mcountinhibit_r <= MCOUNTINHIBIT_RESET & WMASK;
    end else begin
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_r[k] <= cnt_nxt_s[k];
      end
      mcountinhibit_r <= mcountinhibit_nxt_s;
    end
  end

  assign data_rd_out       = rd_s;
  assign addr_hit_out      = hit_s;
  assign mcountinhibit_out = mcountinhibit_r;

endmodule

// File: tb/tb_machine_counter_bank.sv
// Directed bench for machine_counter_bank (NUM_HPM=4, COUNTER_WIDTH=64).
// Inputs change and outputs are sampled in the low clock phase.
module tb_machine_counter_bank;

  logic        clk_in;
  logic        rst_n_in;
  logic [11:0] csr_addr_in;
  logic        wr_en_in;
  logic [31:0] data_wr_in;
  logic        instret_in;
  logic [3:0]  hpm_event_in;
  logic [31:0] data_rd_out;
  logic        addr_hit_out;
  logic [31:0] mcountinhibit_out;

  int nvec;
  int nmis;

  machine_counter_bank dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .csr_addr_in       (csr_addr_in),
    .wr_en_in          (wr_en_in),
    .data_wr_in        (data_wr_in),
    .instret_in        (instret_in),
    .hpm_event_in      (hpm_event_in),
    .data_rd_out       (data_rd_out),
    .addr_hit_out      (addr_hit_out),
    .mcountinhibit_out (mcountinhibit_out)
  );

  initial clk_in = 1'b0;
  always #50 clk_in = ~clk_in;

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic check_rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    csr_addr_in = addr;
    #1;
    nvec++;
    assert (data_rd_out === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, data_rd_out, exp);
    end
  endtask

  task automatic check_hit(input logic [11:0] addr, input logic exp, input string tag);
    csr_addr_in = addr;
    #1;
    nvec++;
    assert (addr_hit_out === exp) else begin
      nmis++;
      $error("FAIL %s: observed %b expected %b", tag, addr_hit_out, exp);
    end
  endtask

  task automatic check_mci(input logic [31:0] exp, input string tag);
    #1;
    nvec++;
    assert (mcountinhibit_out === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, mcountinhibit_out, exp);
    end
  endtask

  // Drive a write in the current low phase; it lands on the next rising edge.
  task automatic csr_write(input logic [11:0] addr, input logic [31:0] d);
    csr_addr_in = addr;
    data_wr_in  = d;
    wr_en_in    = 1'b1;
    @(negedge clk_in);
    wr_en_in    = 1'b0;
  endtask

  task automatic hpm1_pulses(input int n);
    for (int p = 0; p < n; p++) begin
      hpm_event_in = 4'b0010;
      step(1);
      hpm_event_in = 4'b0000;
      step(1);
    end
  endtask

  initial begin
    nvec         = 0;
    nmis         = 0;
    rst_n_in     = 1'b0;
    csr_addr_in  = 12'h000;
    wr_en_in     = 1'b0;
    data_wr_in   = 32'h0000_0000;
    instret_in   = 1'b0;
    hpm_event_in = 4'b0000;

    // 1: reset, 10 idle cycles, asynchronous clear mid-count
    step(2);
    check_rd(12'hB00, 32'h0000_0000, "mcycle_in_reset");
    check_mci(32'h0000_0000, "mci_reset");
    rst_n_in = 1'b1;
    step(10);
    check_rd(12'hB00, 32'h0000_000A, "mcycle_10");
    check_rd(12'hB80, 32'h0000_0000, "mcycleh_10");
    check_rd(12'hB02, 32'h0000_0000, "minstret_idle");
    check_rd(12'hB03, 32'h0000_0000, "hpm3_idle");
    check_rd(12'hB04, 32'h0000_0000, "hpm4_idle");
    check_rd(12'hB05, 32'h0000_0000, "hpm5_idle");
    check_rd(12'hB06, 32'h0000_0000, "hpm6_idle");
    check_hit(12'hB00, 1'b1, "hit_mcycle");
    check_hit(12'hB86, 1'b1, "hit_hpm6h");
    rst_n_in = 1'b0;
    check_rd(12'hB00, 32'h0000_0000, "mcycle_async_clr");
    step(1);
    rst_n_in = 1'b1;

    // 2: carry from low into high half, then full wrap to zero
    csr_write(12'hB00, 32'hFFFF_FFFF);
    csr_write(12'hB80, 32'h0000_0000);
    step(2);
    check_rd(12'hB00, 32'h0000_0001, "mcycle_carry_lo");
    check_rd(12'hB80, 32'h0000_0001, "mcycle_carry_hi");
    csr_write(12'hB00, 32'hFFFF_FFFF);
    csr_write(12'hB80, 32'hFFFF_FFFF);
    check_rd(12'hB80, 32'hFFFF_FFFF, "mcycleh_allones");
    step(1);
    check_rd(12'hB00, 32'h0000_0000, "mcycle_wrap_lo");
    check_rd(12'hB80, 32'h0000_0000, "mcycle_wrap_hi");

    // 3: inhibit everything; the write cycle itself still counts mcycle
    csr_write(12'h320, 32'hFFFF_FFFF);
    check_rd(12'h320, 32'h0000_007D, "mci_masked");
    check_mci(32'h0000_007D, "mci_out_masked");
    for (int c = 0; c < 20; c++) begin
      instret_in   = ~instret_in;
      hpm_event_in = ~hpm_event_in;
      step(1);
    end
    instret_in   = 1'b0;
    hpm_event_in = 4'b0000;
    check_rd(12'hB00, 32'h0000_0001, "mcycle_frozen");
    check_rd(12'hB02, 32'h0000_0000, "minstret_frozen");
    check_rd(12'hB03, 32'h0000_0000, "hpm3_frozen");
    check_rd(12'hB06, 32'h0000_0000, "hpm6_frozen");

    // 4: minstret write suppresses same-cycle retire; mcycle keeps counting
    csr_write(12'h320, 32'h0000_0000);
    check_rd(12'hB00, 32'h0000_0001, "mcycle_old_inhibit");
    instret_in = 1'b1;
    csr_write(12'hB02, 32'h0000_0100);
    instret_in = 1'b0;
    check_rd(12'hB02, 32'h0000_0100, "minstret_wr_suppress");
    check_rd(12'hB00, 32'h0000_0002, "mcycle_during_wr");
    instret_in = 1'b1;
    step(1);
    instret_in = 1'b0;
    check_rd(12'hB02, 32'h0000_0101, "minstret_inc");
    check_rd(12'hB82, 32'h0000_0000, "minstreth");
    check_rd(12'hB00, 32'h0000_0003, "mcycle_3");

    // 5: hpm4 inhibited for first 3 event pulses, enabled for next 4
    csr_write(12'h320, 32'h0000_0010);
    check_rd(12'h320, 32'h0000_0010, "mci_bit4");
    hpm1_pulses(3);
    check_rd(12'hB04, 32'h0000_0000, "hpm4_inhibited");
    csr_write(12'h320, 32'h0000_0000);
    hpm1_pulses(4);
    check_rd(12'hB04, 32'h0000_0004, "hpm4_count");
    check_rd(12'hB03, 32'h0000_0000, "hpm3_untouched");
    check_rd(12'hB05, 32'h0000_0000, "hpm5_untouched");
    csr_write(12'hB84, 32'h0000_0005);
    check_rd(12'hB84, 32'h0000_0005, "hpm4h_wr");
    check_rd(12'hB04, 32'h0000_0004, "hpm4_lo_hold");

    // 6: unmapped addresses read zero, miss, and ignore writes
    check_rd(12'hB1F, 32'h0000_0000, "rd_b1f");
    check_hit(12'hB1F, 1'b0, "hit_b1f");
    check_rd(12'h321, 32'h0000_0000, "rd_321");
    check_hit(12'h321, 1'b0, "hit_321");
    check_hit(12'h320, 1'b1, "hit_320");
    csr_write(12'h321, 32'hFFFF_FFFF);
    csr_write(12'hB1F, 32'hFFFF_FFFF);
    check_mci(32'h0000_0000, "mci_after_unmapped_wr");
    check_rd(12'h320, 32'h0000_0000, "rd_mci_after_unmapped_wr");
    check_rd(12'hB02, 32'h0000_0101, "minstret_after_unmapped_wr");
    check_rd(12'hB04, 32'h0000_0004, "hpm4_after_unmapped_wr");
    check_rd(12'hB84, 32'h0000_0005, "hpm4h_after_unmapped_wr");
    check_rd(12'hB03, 32'h0000_0000, "hpm3_after_unmapped_wr");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
